card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Card source for the blackjack game FSM; replaces free-running counters as the supplier of card values.
- Holds a 52×DECKS shoe as per-rank remaining counts and picks a pseudo-random non-empty rank on each draw request.
- Returns one card per request through a req/valid handshake, tagged with its destination (player or dealer).
- Reports remaining cards, flags an empty shoe, and supports reshuffle without global reset.

Parameters:
DECKS, 1, number of 52-card decks in the shoe; legal values 1..2.
SEED, 8'hA5, LFSR reset value; 0 is illegal and is replaced by 8'h01.

Ports:
Clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
draw_req  input  1  request one card; sampled in IDLE only.
draw_to  input  1  destination of the request: 0 = player, 1 = dealer.
shuffle  input  1  restore a full shoe.
card_valid  output  1  one-cycle pulse; card_value and card_to are valid.
card_value  output  5  card value 1..10; aces = 1, face cards = 10.
card_to  output  1  destination latched from draw_to.
empty_err  output  1  one-cycle pulse when a request hits an empty shoe.
cards_left  output  7  cards remaining in the shoe.
busy  output  1  high while a draw is in progress.

Behaviour:
- Storage: cnt[1..9] initialise to 4×DECKS each; cnt[10] initialises to 16×DECKS. Each count is 6 bits. cards_left initialises to 52×DECKS.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock, including while busy. Loads SEED on reset and never reaches 0.
- Reset, synchronous and taking priority over everything:
  - state = IDLE; all counts full; cards_left full.
  - card_valid = 0, card_value = 0, card_to = 0, empty_err = 0, busy = 0.
- FSM states: IDLE, SCAN, EMPTY.
- IDLE:
  - shuffle = 1: refill all counts and cards_left on that edge; stay in IDLE.
  - Otherwise draw_req = 1 and cards_left = 0: go to EMPTY.
  - Otherwise draw_req = 1 and cards_left > 0:
    - latch draw_to into card_to;
    - ptr = (lfsr mod 10) + 1;
    - go to SCAN; busy rises.
- SCAN examines one rank per clock:
  - cnt[ptr] > 0: decrement cnt[ptr] and cards_left; card_value = ptr; card_valid = 1 for exactly one cycle; return to IDLE.
  - cnt[ptr] = 0: ptr = ptr + 1, wrapping 10 → 1; stay in SCAN.
- Latency: card_valid is high in the 2nd cycle after the edge that samples draw_req when no rank is skipped. Each skipped empty rank adds one cycle. Maximum is 11 cycles, and the scan always terminates because cards_left > 0 at acceptance.
- EMPTY: empty_err = 1 for one cycle, card_valid stays 0, then return to IDLE. Counts are unchanged.
- busy = 1 in SCAN and in EMPTY; 0 in IDLE.
- Simultaneous events and mid-operation requests:
  - draw_req while busy is ignored; nothing is queued.
  - shuffle while busy aborts the draw: no card_valid, no decrement, counts refilled, next state IDLE.
  - shuffle and draw_req together in IDLE: shuffle wins and draw_req is dropped.
  - reset mid-SCAN: no card_valid is issued; shoe returns to full.
- card_value and card_to hold their last values between pulses. card_valid and empty_err are never high in the same cycle.
- Counts never underflow. cards_left always equals the sum of the ten counts.

Test Plan:
- Latency, DECKS=1: after reset, drive draw_req=1 for one cycle with draw_to=1 -> card_valid exactly 2 cycles later, card_value in 1..10, card_to=1, cards_left=51, busy high for 1 cycle.
- Exhaust shoe: issue 52 draws, waiting for each card_valid -> histogram of card_value is 4 each of 1..9 and 16 of 10; cards_left=0; every latency ≤ 11 cycles.
- Empty request: 53rd draw_req -> empty_err pulse 2 cycles later, no card_valid, cards_left stays 0.
- Shuffle: shuffle=1 in IDLE with the shoe empty -> cards_left=52 next cycle; next draw succeeds with 2-cycle latency.
- Busy and abort:
  - draw_req re-asserted the cycle after acceptance -> exactly one card_valid.
  - shuffle asserted while in SCAN -> no card_valid, cards_left=52.
- Reset mid-SCAN: reset during a scan on a depleted shoe -> all outputs 0 the next cycle, cards_left=52 (DECKS=2: 104), LFSR restarts at SEED.

Source files
------------

// File: rtl/card_shoe_if.sv
// Request/response bundle between the blackjack game FSM (master) and the
// card shoe (slave).
interface card_shoe_if;
    logic       draw_req;
    logic       draw_to;
    logic       shuffle;
    logic       card_valid;
    logic [4:0] card_value;
    logic       card_to;
    logic       empty_err;
    logic [6:0] cards_left;
    logic       busy;

    modport master (
        output draw_req, draw_to, shuffle,
        input  card_valid, card_value, card_to, empty_err, cards_left, busy
    );

    modport slave (
        input  draw_req, draw_to, shuffle,
        output card_valid, card_value, card_to, empty_err, cards_left, busy
    );
endinterface

// File: rtl/card_shoe.sv
// Card shoe: per-rank remaining counts for DECKS decks, LFSR-chosen rank,
// one card per request returned through a req/valid handshake.
module card_shoe #(
    parameter int         DECKS = 1,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input logic        Clock,
    input logic        reset,
    card_shoe_if.slave shoe
);

    typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_t;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [5:0] LOW_FULL  = 6'(4 * DECKS);
    localparam logic [5:0] TEN_FULL  = 6'(16 * DECKS);
    localparam logic [6:0] SHOE_FULL = 7'(52 * DECKS);

    state_t     state, state_next;
    logic [3:0] ptr, ptr_next;
    logic [7:0] lfsr;
    logic [5:0] cnt [1:10];
    logic [6:0] cards_left;

    logic       card_valid_q, card_to_q, empty_err_q;
    logic [4:0] card_value_q;

    logic       do_refill, do_take, do_empty, latch_to;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 4'd1;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        do_refill  = 1'b0;
        do_take    = 1'b0;
        do_empty   = 1'b0;
        latch_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (shoe.shuffle) begin
                    do_refill = 1'b1;
                end else if (shoe.draw_req) begin
                    if (cards_left == 7'd0) begin
                        state_next = EMPTY;
                    end else begin
                        state_next = SCAN;
                        latch_to   = 1'b1;
                        ptr_next   = 4'(lfsr % 8'd10) + 4'd1;
                    end
                end
            end
            SCAN: begin
                if (shoe.shuffle) begin
                    do_refill  = 1'b1;
                    state_next = IDLE;
                end else if (cnt[ptr] != 6'd0) begin
                    do_take    = 1'b1;
                    state_next = IDLE;
                end else begin
                    ptr_next = (ptr == 4'd10) ? 4'd1 : ptr + 4'd1;
                end
            end
            EMPTY: begin
                // A shuffle here aborts the failed draw like any other.
                do_refill  = shoe.shuffle;
                do_empty   = ~shoe.shuffle;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the count array is explicitly reset because the shoe contents are
    // architectural state, not scratch storage.
    always_ff @(posedge Clock) begin
        if (reset) begin
            lfsr         <= SEED_EFF;
            cards_left   <= SHOE_FULL;
            for (int i = 1; i <= 10; i++) cnt[i] <= (i == 10) ? TEN_FULL : LOW_FULL;
            card_valid_q <= 1'b0;
            card_value_q <= 5'd0;
            card_to_q    <= 1'b0;
            empty_err_q  <= 1'b0;
        end else begin
            lfsr         <= {lfsr[6:0], lfsr_fb};
            card_valid_q <= do_take;
            empty_err_q  <= do_empty;
            if (latch_to) card_to_q <= shoe.draw_to;
            if (do_take) begin
                card_value_q <= {1'b0, ptr};
                cnt[ptr]     <= cnt[ptr] - 6'd1;
                cards_left   <= cards_left - 7'd1;
            end
            if (do_refill) begin
                cards_left <= SHOE_FULL;
                for (int i = 1; i <= 10; i++) cnt[i] <= (i == 10) ? TEN_FULL : LOW_FULL;
            end
        end
    end

    assign shoe.card_valid = card_valid_q;
    assign shoe.card_value = card_value_q;
    assign shoe.card_to    = card_to_q;
    assign shoe.empty_err  = empty_err_q;
    assign shoe.cards_left = cards_left;
    assign shoe.busy       = (state != IDLE);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe (DECKS=1, SEED=8'hA5): latency, exhaustion,
// empty request, shuffle, busy/abort and reset during a scan.
module tb_card_shoe;

    logic Clock = 1'b0;
    logic reset = 1'b1;

    card_shoe_if bus ();

    card_shoe #(.DECKS(1), .SEED(8'hA5)) dut (
        .Clock (Clock),
        .reset (reset),
        .shoe  (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int hist [1:10];
    int value, lat, nvalid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the shoe idle; returns the card and the number
    // of cycles from the sampling edge to the card_valid cycle (0 = timeout).
    task automatic draw(input logic to, output int v, output int l);
        bus.draw_req = 1'b1;
        bus.draw_to  = to;
        v = 0;
        l = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge Clock);
            bus.draw_req = 1'b0;
            if (bus.card_valid === 1'b1) begin
                v = int'(bus.card_value);
                l = n;
                break;
            end
        end
        check("draw_latency_in_1_11", 32'(l >= 1 && l <= 11), 1);
    endtask

    initial begin
        for (int r = 1; r <= 10; r++) hist[r] = 0;
        bus.draw_req = 1'b0;
        bus.draw_to  = 1'b0;
        bus.shuffle  = 1'b0;
        repeat (2) @(negedge Clock);

        check("rst_card_valid", 32'(bus.card_valid), 0);
        check("rst_card_value", 32'(bus.card_value), 0);
        check("rst_card_to",    32'(bus.card_to), 0);
        check("rst_empty_err",  32'(bus.empty_err), 0);
        check("rst_busy",       32'(bus.busy), 0);
        check("rst_cards_left", 32'(bus.cards_left), 52);

        // First draw right after reset: LFSR = 0xA5 = 165, 165 % 10 + 1 = 6.
        reset        = 1'b0;
        bus.draw_req = 1'b1;
        bus.draw_to  = 1'b1;
        @(negedge Clock);
        bus.draw_req = 1'b0;
        check("first_busy_scan",  32'(bus.busy), 1);
        check("first_no_valid_1", 32'(bus.card_valid), 0);
        @(negedge Clock);
        check("first_valid",      32'(bus.card_valid), 1);
        check("first_value",      32'(bus.card_value), 6);
        check("first_to",         32'(bus.card_to), 1);
        check("first_cards_left", 32'(bus.cards_left), 51);
        check("first_busy_done",  32'(bus.busy), 0);
        if (bus.card_value >= 1 && bus.card_value <= 10) hist[int'(bus.card_value)]++;
        @(negedge Clock);
        check("first_valid_pulse", 32'(bus.card_valid), 0);
        check("first_value_hold",  32'(bus.card_value), 6);

        // Exhaust the remaining 51 cards.
        for (int i = 0; i < 51; i++) begin
            draw(logic'(i[0]), value, lat);
            if (value >= 1 && value <= 10) hist[value]++;
        end
        check("exhaust_cards_left", 32'(bus.cards_left), 0);
        for (int r = 1; r <= 10; r++)
            check($sformatf("hist_rank_%0d", r), 32'(hist[r]), (r == 10) ? 16 : 4);

        // Request on an empty shoe.
        bus.draw_req = 1'b1;
        @(negedge Clock);
        bus.draw_req = 1'b0;
        check("empty_busy",     32'(bus.busy), 1);
        check("empty_err_early", 32'(bus.empty_err), 0);
        @(negedge Clock);
        check("empty_err_pulse",  32'(bus.empty_err), 1);
        check("empty_no_valid",   32'(bus.card_valid), 0);
        check("empty_cards_left", 32'(bus.cards_left), 0);
        @(negedge Clock);
        check("empty_err_clear",  32'(bus.empty_err), 0);

        // Shuffle from empty, then a draw on a full shoe never skips.
        bus.shuffle = 1'b1;
        @(negedge Clock);
        bus.shuffle = 1'b0;
        check("shuffle_cards_left", 32'(bus.cards_left), 52);
        draw(1'b0, value, lat);
        check("shuffle_draw_latency", 32'(lat), 2);
        check("shuffle_draw_to",      32'(bus.card_to), 0);
        check("shuffle_draw_left",    32'(bus.cards_left), 51);

        // Shuffle and draw_req together in IDLE: shuffle wins.
        bus.shuffle  = 1'b1;
        bus.draw_req = 1'b1;
        @(negedge Clock);
        bus.shuffle  = 1'b0;
        bus.draw_req = 1'b0;
        check("both_busy",       32'(bus.busy), 0);
        check("both_cards_left", 32'(bus.cards_left), 52);
        nvalid = 0;
        repeat (3) begin
            @(negedge Clock);
            nvalid += int'(bus.card_valid);
        end
        check("both_no_valid", 32'(nvalid), 0);

        // draw_req held into the SCAN cycle yields exactly one card.
        bus.draw_req = 1'b1;
        nvalid = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge Clock);
            if (n >= 2) bus.draw_req = 1'b0;
            nvalid += int'(bus.card_valid);
        end
        check("busy_one_valid",  32'(nvalid), 1);
        check("busy_cards_left", 32'(bus.cards_left), 51);

        // Shuffle during SCAN aborts the draw.
        bus.draw_req = 1'b1;
        @(negedge Clock);
        bus.draw_req = 1'b0;
        check("abort_in_scan", 32'(bus.busy), 1);
        bus.shuffle = 1'b1;
        @(negedge Clock);
        bus.shuffle = 1'b0;
        check("abort_no_valid",   32'(bus.card_valid), 0);
        check("abort_busy",       32'(bus.busy), 0);
        check("abort_cards_left", 32'(bus.cards_left), 52);
        nvalid = 0;
        repeat (3) begin
            @(negedge Clock);
            nvalid += int'(bus.card_valid);
        end
        check("abort_no_late_valid", 32'(nvalid), 0);

        // Deplete most of the shoe, then reset in the middle of a scan.
        for (int i = 0; i < 45; i++) draw(1'b1, value, lat);
        check("deplete_cards_left", 32'(bus.cards_left), 7);
        bus.draw_req = 1'b1;
        bus.draw_to  = 1'b1;
        @(negedge Clock);
        bus.draw_req = 1'b0;
        check("midscan_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge Clock);
        check("midrst_card_valid", 32'(bus.card_valid), 0);
        check("midrst_card_value", 32'(bus.card_value), 0);
        check("midrst_card_to",    32'(bus.card_to), 0);
        check("midrst_empty_err",  32'(bus.empty_err), 0);
        check("midrst_busy",       32'(bus.busy), 0);
        check("midrst_cards_left", 32'(bus.cards_left), 52);

        // LFSR restarted at SEED: the first draw is rank 6 again.
        reset        = 1'b0;
        bus.draw_req = 1'b1;
        bus.draw_to  = 1'b0;
        @(negedge Clock);
        bus.draw_req = 1'b0;
        @(negedge Clock);
        check("reseed_valid", 32'(bus.card_valid), 1);
        check("reseed_value", 32'(bus.card_value), 6);
        check("reseed_to",    32'(bus.card_to), 0);
        check("reseed_left",  32'(bus.cards_left), 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
